// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer: FSM states, display blink codes,
// default divider ratios for a 50 MHz system clock.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } sw_state_t;

  localparam logic [1:0] BLINK_STEADY_IDLE = 2'b00;
  localparam logic [1:0] BLINK_STEADY_RUN  = 2'b01;
  localparam logic [1:0] BLINK_PAUSE       = 2'b10;
  localparam logic [1:0] BLINK_DONE        = 2'b11;

  localparam int DEFAULT_CLK_DIV   = 500000;
  localparam int DEFAULT_BLINK_DIV = 12500000;

  function automatic logic [1:0] blink_code(input sw_state_t s);
    logic [1:0] code;
    code = BLINK_STEADY_IDLE;
    case (s)
      IDLE:    code = BLINK_STEADY_IDLE;
      RUN:     code = BLINK_STEADY_RUN;
      PAUSE:   code = BLINK_PAUSE;
      DONE:    code = BLINK_DONE;
      default: code = BLINK_STEADY_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one raw button; press is a 1-cycle pulse
// valid after the 2nd edge following a raw rise, so the consumer acts on the 3rd edge. No backpressure.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign press = sync & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, run/pause/done FSM, count-enable prescaler, blink drive.
// All outputs registered (one cycle after the deciding cycle); STOPWATCH_LAP_EN adds lap_button/lap_hold.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop_button,
  input  logic       reset_button,
  input  logic       equal,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_button,
  output logic       lap_hold,
`endif
  output logic       count_en,
  output logic       count_clr,
  output logic [1:0] blink,
  output logic       blink_phase,
  output logic [1:0] state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic ss_press;
  logic rst_press;

  btn_sync_edge u_ss_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (start_stop_button),
    .press (ss_press)
  );

  btn_sync_edge u_rst_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (reset_button),
    .press (rst_press)
  );

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_en_q, count_en_d;
  logic          count_clr_q, count_clr_d;
  logic [1:0]    blink_q, blink_d;
  logic          stay_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      blink_q     <= BLINK_STEADY_IDLE;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    count_en_d  = 1'b0;
    count_clr_d = 1'b0;
    stay_run    = 1'b0;

    // Reset press overrides everything; a coincident start_stop press is dropped.
    if (rst_press) begin
      state_d     = IDLE;
      count_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (ss_press) state_d = equal ? DONE : RUN;
        RUN: begin
          if (ss_press)   state_d = PAUSE;
          else if (equal) state_d = DONE;
        end
        PAUSE:   if (ss_press) state_d = equal ? DONE : RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    // The prescaler only advances while RUN is kept, so leaving RUN freezes the sub-tick fraction.
    stay_run = (state_q == RUN) && (state_d == RUN);

    if (rst_press) begin
      presc_d = '0;
    end else if (stay_run) begin
      if (presc_q == PRESC_MAX) begin
        presc_d    = '0;
        count_en_d = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    blink_d = blink_code(state_d);
  end

  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_press;
  logic lap_hold_q;

  btn_sync_edge u_lap_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (lap_button),
    .press (lap_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_hold_q <= 1'b0;
    end else if (rst_press || (state_d == DONE && state_q != DONE)) begin
      lap_hold_q <= 1'b0;
    end else if (lap_press && (state_q == RUN || state_q == PAUSE)) begin
      lap_hold_q <= ~lap_hold_q;
    end
  end

  assign lap_hold = lap_hold_q;
`endif

  assign count_en    = count_en_q;
  assign count_clr   = count_clr_q;
  assign blink       = blink_q;
  assign blink_phase = blink_phase_q;
  assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4, BLINK_DIV=3: per-cycle vector table plus
// hand-written sequences for async reset, blink phase and the optional lap feature.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_stop_button;
  logic       reset_button;
  logic       equal;
  logic       count_en;
  logic       count_clr;
  logic [1:0] blink;
  logic       blink_phase;
  logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
  logic       lap_button;
  logic       lap_hold;
`endif

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.CLK_DIV(4), .BLINK_DIV(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_stop_button (start_stop_button),
    .reset_button      (reset_button),
    .equal             (equal),
`ifdef STOPWATCH_LAP_EN
    .lap_button        (lap_button),
    .lap_hold          (lap_hold),
`endif
    .count_en          (count_en),
    .count_clr         (count_clr),
    .blink             (blink),
    .blink_phase       (blink_phase),
    .state             (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       rb;
    logic       eq;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic [1:0] bl;
  } vec_t;

  localparam int NV = 43;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic ss, input logic rb, input logic eq,
                              input logic [1:0] st, input logic en, input logic clr,
                              input logic [1:0] bl);
    vec_t v;
    v.ss = ss; v.rb = rb; v.eq = eq;
    v.st = st; v.en = en; v.clr = clr; v.bl = bl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ss, input logic rb, input logic eq);
    @(negedge clk);
    start_stop_button = ss;
    reset_button      = rb;
    equal             = eq;
    @(posedge clk);
    #1;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic lap_step(input logic lp, input logic rb);
    @(negedge clk);
    lap_button        = lp;
    reset_button      = rb;
    start_stop_button = 1'b0;
    equal             = 1'b0;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    bit found;
    int pulses;

    // Row fields: ss rb eq -> state count_en count_clr blink (sampled after the edge)
    tbl[0]  = mk(1,0,0, 2'd0,0,0,2'd0);
    tbl[1]  = mk(1,0,0, 2'd0,0,0,2'd0);
    tbl[2]  = mk(1,0,0, 2'd1,0,0,2'd1);
    tbl[3]  = mk(1,0,0, 2'd1,0,0,2'd1);
    tbl[4]  = mk(1,0,0, 2'd1,0,0,2'd1);
    tbl[5]  = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[6]  = mk(0,0,0, 2'd1,1,0,2'd1);
    tbl[7]  = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[8]  = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[9]  = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[10] = mk(0,0,0, 2'd1,1,0,2'd1);
    tbl[11] = mk(1,0,0, 2'd1,0,0,2'd1);
    tbl[12] = mk(1,0,0, 2'd1,0,0,2'd1);
    tbl[13] = mk(0,0,0, 2'd2,0,0,2'd2);
    tbl[14] = mk(0,0,0, 2'd2,0,0,2'd2);
    tbl[15] = mk(0,0,0, 2'd2,0,0,2'd2);
    tbl[16] = mk(1,0,0, 2'd2,0,0,2'd2);
    tbl[17] = mk(1,0,0, 2'd2,0,0,2'd2);
    tbl[18] = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[19] = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[20] = mk(0,0,0, 2'd1,1,0,2'd1);
    tbl[21] = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[22] = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[23] = mk(0,0,0, 2'd1,0,0,2'd1);
    tbl[24] = mk(0,0,1, 2'd3,0,0,2'd3);
    tbl[25] = mk(1,0,0, 2'd3,0,0,2'd3);
    tbl[26] = mk(1,0,0, 2'd3,0,0,2'd3);
    tbl[27] = mk(0,0,0, 2'd3,0,0,2'd3);
    tbl[28] = mk(0,0,0, 2'd3,0,0,2'd3);
    tbl[29] = mk(1,1,0, 2'd3,0,0,2'd3);
    tbl[30] = mk(1,1,0, 2'd3,0,0,2'd3);
    tbl[31] = mk(1,1,0, 2'd0,0,1,2'd0);
    tbl[32] = mk(1,1,0, 2'd0,0,0,2'd0);
    tbl[33] = mk(0,0,0, 2'd0,0,0,2'd0);
    tbl[34] = mk(0,0,0, 2'd0,0,0,2'd0);
    tbl[35] = mk(0,0,0, 2'd0,0,0,2'd0);
    tbl[36] = mk(1,0,1, 2'd0,0,0,2'd0);
    tbl[37] = mk(1,0,1, 2'd0,0,0,2'd0);
    tbl[38] = mk(0,0,1, 2'd3,0,0,2'd3);
    tbl[39] = mk(0,1,0, 2'd3,0,0,2'd3);
    tbl[40] = mk(0,1,0, 2'd3,0,0,2'd3);
    tbl[41] = mk(0,0,0, 2'd0,0,1,2'd0);
    tbl[42] = mk(0,0,0, 2'd0,0,0,2'd0);

    rst_n             = 1'b0;
    start_stop_button = 1'b1;
    reset_button      = 1'b1;
    equal             = 1'b1;
`ifdef STOPWATCH_LAP_EN
    lap_button        = 1'b1;
`endif

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d state", i), state, 0);
      chk($sformatf("rst%0d count_en", i), count_en, 0);
      chk($sformatf("rst%0d count_clr", i), count_clr, 0);
      chk($sformatf("rst%0d blink", i), blink, 0);
      chk($sformatf("rst%0d blink_phase", i), blink_phase, 0);
    end

    @(negedge clk);
    start_stop_button = 1'b0;
    reset_button      = 1'b0;
    equal             = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_button        = 1'b0;
`endif
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].ss, tbl[i].rb, tbl[i].eq);
      chk($sformatf("row%0d state", i), state, tbl[i].st);
      chk($sformatf("row%0d count_en", i), count_en, tbl[i].en);
      chk($sformatf("row%0d count_clr", i), count_clr, tbl[i].clr);
      chk($sformatf("row%0d blink", i), blink, tbl[i].bl);
    end

    // Async reset while count_en is high, then blink_phase restart.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("arst run state", state, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (count_en === 1'b1) found = 1'b1;
    end
    chk("arst count_en seen", {31'd0, found}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst count_en drop", count_en, 0);
    chk("arst state", state, 0);
    chk("arst blink", blink, 0);
    chk("arst blink_phase", blink_phase, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) chk("post arst state", state, 0);
      chk($sformatf("phase edge%0d", i), blink_phase, (i / 3) % 2);
    end

`ifdef STOPWATCH_LAP_EN
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("lap run state", state, 1);
    chk("lap hold init", lap_hold, 0);
    lap_step(1, 0);
    lap_step(1, 0);
    lap_step(0, 0);
    chk("lap hold set", lap_hold, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      if (count_en === 1'b1) pulses++;
    end
    chk("lap count_en pulses", pulses, 2);
    chk("lap hold kept", lap_hold, 1);
    lap_step(1, 0);
    lap_step(1, 0);
    lap_step(0, 0);
    chk("lap hold cleared", lap_hold, 0);
    lap_step(1, 0);
    lap_step(1, 0);
    lap_step(0, 0);
    chk("lap hold reset", lap_hold, 1);
    lap_step(0, 1);
    lap_step(0, 1);
    lap_step(0, 0);
    chk("lap hold after rst press", lap_hold, 0);
    chk("lap state after rst press", state, 0);
`else
    pulses = 0;
    chk("lap disabled state", state + pulses, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
